raster_framebuffer_dbuf: RTL and testbench

Parametrised double-buffered (ping-pong) pixel framebuffer for the raster laser projector.
- Host side: Avalon-MM slave that always writes and reads the back bank.
- Scan-out side: a pipelined read port that always reads the front bank.
- Banks swap only on a frame boundary, so the projector never scans a half-drawn frame.
- Replaces the single-bank dual-port framebuffer in the Qsys system.

---
 rtl/raster_framebuffer_dbuf.sv | 216 +++++++++++++++++++++
 tb/tb_raster_framebuffer_dbuf.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_framebuffer_dbuf.sv
// Double-buffered (ping-pong) pixel framebuffer: host port on the back bank, pipelined scan port on the front bank.
// Optional clear-on-swap engine is compiled in with `define RASTER_FB_CLEAR_ON_SWAP_EN.
module raster_framebuffer_dbuf #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 19,
  parameter int unsigned       DEPTH       = 307200,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s_address,
  input  logic              s_chipselect,
  input  logic              s_write,
  input  logic              s_read,
  input  logic [DATA_W-1:0] s_writedata,
  output logic [DATA_W-1:0] s_readdata,
  output logic              s_readdatavalid,
  output logic              s_waitrequest,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_address,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic              swap_req,
  input  logic              frame_start,
  output logic              swap_pending,
  output logic              front_bank
);

  localparam int unsigned       PA_W     = ADDR_W + 1;
  localparam logic [PA_W-1:0]   DEPTH_PA = PA_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(DEPTH - 1);

`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_CLEAR} state_t;
`else
  typedef enum logic {S_IDLE, S_PENDING} state_t;
`endif

  state_t state, state_n;
  logic   front_n;
  logic   take;

`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
  logic [ADDR_W-1:0] clr_cnt, clr_n;
  logic              swap_latch, latch_n;
  logic              latched;
`endif

  logic [DATA_W-1:0] mem [2*DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] off);
    return ({1'b0, off} < DEPTH_PA);
  endfunction

  // Banks sit back to back: bank 1 starts at DEPTH, not at 2^ADDR_W.
  function automatic logic [PA_W-1:0] phys(input logic bank, input logic [ADDR_W-1:0] off);
    return bank ? ({1'b0, off} + DEPTH_PA) : {1'b0, off};
  endfunction

  function automatic logic [PA_W-1:0] rd_index(input logic bank, input logic [ADDR_W-1:0] off);
    return in_range(off) ? phys(bank, off) : '0;
  endfunction

  logic back_bank;
  logic host_wr, host_rd;

  assign back_bank = ~front_bank;
  assign host_wr   = s_chipselect & s_write & ~s_waitrequest;
  // A read colliding with a write in the same cycle is dropped; only the write proceeds.
  assign host_rd   = s_chipselect & s_read & ~s_write & ~s_waitrequest;

  // ------------------------------------------------------------------
  // Write port arbitration (host or clear engine)
  // ------------------------------------------------------------------
  logic              wr_en;
  logic [PA_W-1:0]   wr_addr;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    wr_en   = host_wr & in_range(s_address);
    wr_addr = phys(back_bank, s_address);
    wr_data = host_wr ? s_writedata : CLEAR_VALUE;
`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
    if (state == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = phys(back_bank, clr_cnt);
      wr_data = CLEAR_VALUE;
    end
`endif
  end

  // ------------------------------------------------------------------
  // Pipeline / response registers
  // ------------------------------------------------------------------
  logic              host_valid, host_oor;
  logic              scan_s1_req, scan_s1_bank;
  logic [ADDR_W-1:0] scan_s1_addr;
  logic              scan_s2_valid, scan_s2_oor;
  logic [DATA_W-1:0] host_q, scan_q;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
    if (host_rd)
      host_q <= mem[rd_index(back_bank, s_address)];
    if (scan_s1_req)
      scan_q <= mem[rd_index(scan_s1_bank, scan_s1_addr)];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      host_valid    <= 1'b0;
      host_oor      <= 1'b0;
      scan_s1_req   <= 1'b0;
      scan_s1_bank  <= 1'b0;
      scan_s1_addr  <= '0;
      scan_s2_valid <= 1'b0;
      scan_s2_oor   <= 1'b0;
    end else begin
      host_valid <= host_rd;
      if (host_rd)
        host_oor <= ~in_range(s_address);
      scan_s1_req <= scan_req;
      if (scan_req) begin
        scan_s1_addr <= scan_address;
        scan_s1_bank <= front_bank;
      end
      scan_s2_valid <= scan_s1_req;
      if (scan_s1_req)
        scan_s2_oor <= ~in_range(scan_s1_addr);
    end
  end

  assign s_readdatavalid = host_valid;
  assign s_readdata      = (host_valid & ~host_oor) ? host_q : '0;
  assign scan_valid      = scan_s2_valid;
  assign scan_data       = (scan_s2_valid & ~scan_s2_oor) ? scan_q : '0;

  // ------------------------------------------------------------------
  // Swap FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      front_bank <= 1'b0;
`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
      clr_cnt    <= '0;
      swap_latch <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      front_bank <= front_n;
`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
      clr_cnt    <= clr_n;
      swap_latch <= latch_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    front_n = front_bank;
    take    = 1'b0;
`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
    clr_n   = clr_cnt;
    latch_n = swap_latch;
    latched = swap_latch | swap_req;
`endif
    case (state)
      S_IDLE: begin
        if (swap_req && frame_start)
          take = 1'b1;
        else if (swap_req)
          state_n = S_PENDING;
      end
      S_PENDING: begin
        if (frame_start)
          take = 1'b1;
      end
`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
      S_CLEAR: begin
        // frame_start is ignored here; a swap request waits until the bank is clean.
        latch_n = latched;
        if (clr_cnt == LAST_OFF) begin
          state_n = latched ? S_PENDING : S_IDLE;
          latch_n = 1'b0;
          clr_n   = '0;
        end else begin
          clr_n = clr_cnt + 1'b1;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    if (take) begin
      front_n = ~front_bank;
`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
      state_n = S_CLEAR;
      clr_n   = '0;
`else
      state_n = S_IDLE;
`endif
    end
  end

  always_comb begin
    swap_pending  = (state == S_PENDING);
    s_waitrequest = 1'b0;
`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
    swap_pending  = (state == S_PENDING) | swap_latch;
    s_waitrequest = (state == S_CLEAR);
`endif
  end

endmodule

// File: tb/tb_raster_framebuffer_dbuf.sv
// Scoreboard bench for raster_framebuffer_dbuf: directed stimulus pushes expected read/scan responses,
// monitors pop and compare data and arrival cycle.
module tb_raster_framebuffer_dbuf;

  localparam int unsigned DATA_W = 8;
`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
`else
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DEPTH  = 307200;
`endif
  localparam logic [DATA_W-1:0] CLR = 8'h3C;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] s_address;
  logic              s_chipselect, s_write, s_read;
  logic [DATA_W-1:0] s_writedata, s_readdata;
  logic              s_readdatavalid, s_waitrequest;
  logic              scan_req;
  logic [ADDR_W-1:0] scan_address;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic              swap_req, frame_start;
  logic              swap_pending, front_bank;

  raster_framebuffer_dbuf #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CLEAR_VALUE(CLR)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write(s_write), .s_read(s_read),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_waitrequest(s_waitrequest),
    .scan_req(scan_req), .scan_address(scan_address), .scan_data(scan_data), .scan_valid(scan_valid),
    .swap_req(swap_req), .frame_start(frame_start), .swap_pending(swap_pending), .front_bank(front_bank)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    int unsigned       due;
  } exp_t;

  exp_t host_q[$];
  exp_t scan_q[$];
  exp_t he, se;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents data.
  always @(negedge clk) begin
    if (reset_n) begin
      if (s_readdatavalid) begin
        if (host_q.size() == 0) check("host unexpected valid", 32'd1, 32'd0);
        else begin
          he = host_q.pop_front();
          check("host data", 32'(s_readdata), 32'(he.data));
          check("host latency", cyc, he.due);
        end
      end
      if (scan_valid) begin
        if (scan_q.size() == 0) check("scan unexpected valid", 32'd1, 32'd0);
        else begin
          se = scan_q.pop_front();
          check("scan data", 32'(scan_data), 32'(se.data));
          check("scan latency", cyc, se.due);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    tick();
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic hread(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    host_q.push_back('{exp, cyc + 1});
    tick();
    s_chipselect = 1'b0; s_read = 1'b0;
  endtask

  task automatic sread(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    scan_req = 1'b1; scan_address = a;
    scan_q.push_back('{exp, cyc + 2});
    tick();
    scan_req = 1'b0;
  endtask

  task automatic swap_now;
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned k;

  initial begin
    reset_n = 1'b0;
    s_address = '0; s_chipselect = 1'b0; s_write = 1'b0; s_read = 1'b0; s_writedata = '0;
    scan_req = 1'b0; scan_address = '0; swap_req = 1'b0; frame_start = 1'b0;
    #3;
    check("rst s_readdata", 32'(s_readdata), 32'd0);
    check("rst s_readdatavalid", 32'(s_readdatavalid), 32'd0);
    check("rst s_waitrequest", 32'(s_waitrequest), 32'd0);
    check("rst scan_data", 32'(scan_data), 32'd0);
    check("rst scan_valid", 32'(scan_valid), 32'd0);
    check("rst swap_pending", 32'(swap_pending), 32'd0);
    check("rst front_bank", 32'(front_bank), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

`ifdef RASTER_FB_CLEAR_ON_SWAP_EN
    // Fill bank 1 with non-clear data, then swap: bank 0 becomes back and is cleared.
    for (int i = 0; i < 16; i++) hwrite(ADDR_W'(i), 8'hF0 + 8'(i));
    swap_now();
    k = 0;
    while (s_waitrequest === 1'b1 && k < 100) begin
      swap_req    = (k == 4);
      frame_start = (k == 4) || (k == 6);
      tick();
      k++;
    end
    swap_req = 1'b0; frame_start = 1'b0;
    check("clear1 waitrequest cycles", k, 32'd16);
    check("clear1 front_bank", 32'(front_bank), 32'd1);
    check("latched swap pending", 32'(swap_pending), 32'd1);

    // Latched swap taken: bank 1 becomes back and is cleared; host write stalls across it.
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("swap2 front_bank", 32'(front_bank), 32'd0);
    check("clear2 waitrequest", 32'(s_waitrequest), 32'd1);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = 4'd5; s_writedata = 8'h5A;
    k = 0;
    while (s_waitrequest === 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("clear2 waitrequest cycles", k, 32'd16);
    tick();
    s_chipselect = 1'b0; s_write = 1'b0;
    check("post clear pending", 32'(swap_pending), 32'd0);
    for (int i = 0; i < 16; i++) hread(ADDR_W'(i), (i == 5) ? 8'h5A : CLR);
    sread(4'd3, CLR);
    sread(4'd15, CLR);
`else
    // Preload: bank 1 via host, swap, bank 0 via host, swap back.
    for (int i = 0; i < 4; i++) hwrite(ADDR_W'(i), 8'h10 + 8'(i));
    hwrite(19'd10, 8'h55);
    swap_now();
    check("same-cycle swap front_bank", 32'(front_bank), 32'd1);
    check("same-cycle swap pending", 32'(swap_pending), 32'd0);
    for (int i = 0; i < 4; i++) hwrite(ADDR_W'(i), 8'h20 + 8'(i));
    hwrite(19'd10, 8'h00);
    swap_now();
    check("preload front_bank", 32'(front_bank), 32'd0);

    // Host write/read on back bank, scan sees front bank.
    hwrite(19'd10, 8'hA5);
    hread(19'd10, 8'hA5);
    sread(19'd10, 8'h00);

    // Deferred swap: pending for five cycles, then taken on frame_start.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("pending while waiting", 32'(swap_pending), 32'd1);
      if (i == 4) frame_start = 1'b1;
      tick();
    end
    frame_start = 1'b0;
    check("deferred swap pending", 32'(swap_pending), 32'd0);
    check("deferred swap front_bank", 32'(front_bank), 32'd1);
    sread(19'd10, 8'hA5);

    // Double request gives one toggle; lone frame_start does nothing.
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("double req pending", 32'(swap_pending), 32'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("double req front_bank", 32'(front_bank), 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    check("lone frame_start front_bank", 32'(front_bank), 32'd0);
    check("lone frame_start pending", 32'(swap_pending), 32'd0);

    // Back-to-back scan with a swap alongside the second request.
    for (int i = 0; i < 4; i++) begin
      scan_req = 1'b1; scan_address = ADDR_W'(i);
      scan_q.push_back('{(i < 2) ? 8'h20 + 8'(i) : 8'h10 + 8'(i), cyc + 2});
      swap_req = (i == 1); frame_start = (i == 1);
      tick();
    end
    scan_req = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
    check("scan swap front_bank", 32'(front_bank), 32'd1);
    repeat (3) tick();

    // Out-of-range accesses; read colliding with a write.
    hwrite(ADDR_W'(DEPTH), 8'h77);
    hread(ADDR_W'(DEPTH), 8'h00);
    hread(19'd0, 8'h20);
    sread(ADDR_W'(DEPTH), 8'h00);
    s_chipselect = 1'b1; s_write = 1'b1; s_read = 1'b1; s_address = 19'd1; s_writedata = 8'h99;
    tick();
    s_chipselect = 1'b0; s_write = 1'b0; s_read = 1'b0;
    repeat (2) tick();
    hread(19'd1, 8'h99);

    // Host write on the swap edge lands in the old back bank (bank 0).
    s_chipselect = 1'b1; s_write = 1'b1; s_address = 19'd2; s_writedata = 8'h44;
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    s_chipselect = 1'b0; s_write = 1'b0; swap_req = 1'b0; frame_start = 1'b0;
    check("write-on-swap front_bank", 32'(front_bank), 32'd0);
    hread(19'd2, 8'h12);
    sread(19'd2, 8'h44);
`endif

    repeat (5) tick();
    check("host responses outstanding", 32'(host_q.size()), 32'd0);
    check("scan responses outstanding", 32'(scan_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
